gascon_perm_ctrl: RTL and testbench

Initiator-side sequencer for the Gascon round core. It accepts a 320-bit state and a round count, then drives the round core once per round. For each round it pulses the core's synchronous reset, holds the state and round index stable, waits for the core's `done`, and captures the core output as the next state. It sits between the AEAD mode controller and the round core, and returns the permuted state over a valid/ready output handshake.

---
 rtl/gascon_pkg.sv | 19 +
 rtl/gascon_round_sched.sv | 38 +++
 rtl/gascon_perm_ctrl.sv | 145 ++++++++++++++
 tb/tb_gascon_perm_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gascon_pkg.sv
// Shared types and constants for the Gascon permutation sequencer.
package gascon_pkg;

  localparam int CWIDTH     = 320;
  localparam int MAX_ROUNDS = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CORE_RST = 2'd1,
    ST_CORE_RUN = 2'd2,
    ST_OUT      = 2'd3
  } perm_state_t;

  // Round constant for round index r: high nibble is 0xF - r, low nibble is r.
  function automatic logic [7:0] rc(input logic [3:0] r);
    rc = {4'hF - r, r};
  endfunction

endpackage

// File: rtl/gascon_round_sched.sv
// Round scheduler: tracks the current round index and how many rounds remain.
module gascon_round_sched #(
  parameter int MAX_ROUNDS = gascon_pkg::MAX_ROUNDS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] num_rounds,
  input  logic       step,
  output logic [3:0] rnd,
  output logic       last
);

  logic [3:0] w_a;
  logic [3:0] r_rnd;
  logic [3:0] r_rem;

  // Requests beyond the supported round count are clamped.
  assign w_a = (num_rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : num_rounds;

  // Load the first round index and remaining count, then advance once per captured round.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rnd <= 4'd0;
      r_rem <= 4'd0;
    end else if (load) begin
      r_rnd <= 4'(MAX_ROUNDS) - w_a;
      r_rem <= w_a;
    end else if (step) begin
      r_rnd <= r_rnd + 4'd1;
      r_rem <= r_rem - 4'd1;
    end
  end

  assign rnd  = r_rnd;
  assign last = (r_rem == 4'd1);

endmodule

// File: rtl/gascon_perm_ctrl.sv
// Sequencer that drives an external Gascon round core once per round and
// returns the permuted state over a valid/ready handshake.
module gascon_perm_ctrl #(
  parameter int CWIDTH      = gascon_pkg::CWIDTH,
  parameter int ROUND_COUNT = 16,
  parameter int MAX_ROUNDS  = gascon_pkg::MAX_ROUNDS,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [3:0]             num_rounds,
  input  logic [CWIDTH-1:0]      state_in,
  output logic                   in_ready,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [CWIDTH-1:0]      state_out,
  output logic                   error,
  output logic [CWIDTH-1:0]      core_c,
  output logic [ROUND_COUNT-1:0] core_round,
  output logic                   core_en,
  output logic                   core_reset,
  input  logic [CWIDTH-1:0]      core_cout,
  input  logic                   core_done
);

  import gascon_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT);

  perm_state_t       r_state;
  perm_state_t       w_state_next;
  logic [CWIDTH-1:0] r_st;
  logic [WD_W-1:0]   r_wd;
  logic              r_error;
  logic              w_accept;
  logic              w_capture;
  logic              w_timeout;
  logic              w_last;
  logic [3:0]        w_rnd;
  logic              w_in_ready;
  logic              w_dout_valid;
  logic              w_core_en;
  logic              w_core_rst;

  assign w_accept  = (r_state == ST_IDLE) && start;
  // core_done is only looked at in CORE_RUN, so a sticky done left over
  // from the previous round is never mistaken for a fresh result.
  assign w_capture = (r_state == ST_CORE_RUN) && core_done;
  assign w_timeout = (r_state == ST_CORE_RUN) && !core_done && (r_wd == WD_W'(TIMEOUT - 1));

  gascon_round_sched #(
    .MAX_ROUNDS (MAX_ROUNDS)
  ) u_sched (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (w_accept),
    .num_rounds (num_rounds),
    .step       (w_capture),
    .rnd        (w_rnd),
    .last       (w_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_dout_valid = 1'b0;
    w_core_en    = 1'b0;
    w_core_rst   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (start) begin
          w_state_next = (num_rounds == 4'd0) ? ST_OUT : ST_CORE_RST;
        end
      end
      ST_CORE_RST: begin
        w_state_next = ST_CORE_RUN;
      end
      ST_CORE_RUN: begin
        w_core_en  = 1'b1;
        w_core_rst = 1'b0;
        if (core_done) begin
          w_state_next = w_last ? ST_OUT : ST_CORE_RST;
        end else if (w_timeout) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_OUT: begin
        w_dout_valid = 1'b1;
        if (dout_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Working state, per-round watchdog and sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st    <= '0;
      r_wd    <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_st    <= state_in;
        r_error <= 1'b0;
      end else if (w_capture) begin
        r_st <= core_cout;
      end
      if (r_state == ST_CORE_RST) begin
        r_wd <= '0;
      end else if (r_state == ST_CORE_RUN) begin
        r_wd <= r_wd + WD_W'(1);
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign dout_valid = w_dout_valid;
  assign state_out  = r_st;
  assign error      = r_error;
  assign core_c     = r_st;
  assign core_round = ROUND_COUNT'(w_rnd);
  assign core_en    = w_core_en;
  // Keep the core in reset while our own reset is asserted, independent of state.
  assign core_reset = ~reset_n | w_core_rst;

endmodule

// File: tb/tb_gascon_perm_ctrl.sv
// Self-checking bench for gascon_perm_ctrl with a stub round core
// (done L cycles after enable, cout = c + 1) and a result scoreboard.
module tb_gascon_perm_ctrl;

  import gascon_pkg::*;

  localparam int CW     = 320;
  localparam int RCW    = 16;
  localparam int TO     = 16;
  localparam int STUB_L = 5;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [3:0]     num_rounds;
  logic [CW-1:0]  state_in;
  logic           in_ready;
  logic           dout_valid;
  logic           dout_ready;
  logic [CW-1:0]  state_out;
  logic           error;
  logic [CW-1:0]  core_c;
  logic [RCW-1:0] core_round;
  logic           core_en;
  logic           core_reset;
  logic [CW-1:0]  core_cout;
  logic           core_done;

  gascon_perm_ctrl #(
    .CWIDTH      (CW),
    .ROUND_COUNT (RCW),
    .MAX_ROUNDS  (12),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .num_rounds (num_rounds),
    .state_in   (state_in),
    .in_ready   (in_ready),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .state_out  (state_out),
    .error      (error),
    .core_c     (core_c),
    .core_round (core_round),
    .core_en    (core_en),
    .core_reset (core_reset),
    .core_cout  (core_cout),
    .core_done  (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub round core.
  int   stub_cnt = 0;
  logic stub_hang;
  always @(posedge clk) begin
    if (core_reset) stub_cnt <= 0;
    else if (core_en) stub_cnt <= stub_cnt + 1;
  end
  assign core_done = !stub_hang && core_en && (stub_cnt >= STUB_L - 1);
  assign core_cout = core_c + CW'(1);

  // Monitors: cycle count, enabled cycles, captured round indices.
  int         cyc = 0;
  int         en_cnt = 0;
  logic [3:0] rounds_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_en) en_cnt <= en_cnt + 1;
    if (core_en && core_done) rounds_q.push_back(core_round[3:0]);
  end

  logic [CW-1:0] sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_in_ready"},   in_ready,   1);
    check({pfx, "_dout_valid"}, dout_valid, 0);
    check({pfx, "_error"},      error,      0);
    check({pfx, "_state_out"},  state_out,  0);
    check({pfx, "_core_c"},     core_c,     0);
    check({pfx, "_core_round"}, core_round, 0);
    check({pfx, "_core_en"},    core_en,    0);
    check({pfx, "_core_reset"}, core_reset, 1);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_perm(input logic [3:0] a, input logic [CW-1:0] st,
                            output int c0, output int en0, output int rq0);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("start_ready", in_ready, 1);
    start      = 1'b1;
    num_rounds = a;
    state_in   = st;
    c0  = cyc;
    en0 = en_cnt;
    rq0 = rounds_q.size();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input int a, input int exp_lat, input int c0, input int hold);
    int            g;
    logic [CW-1:0] held;
    logic [CW-1:0] exp;
    bit            stable;
    g = 0;
    while (!dout_valid && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("dout_valid_seen", dout_valid, 1);
    if (!dout_valid) return;
    check("latency", cyc - c0, exp_lat);
    if (hold > 0) begin
      held   = state_out;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        start      = 1'b1;
        num_rounds = 4'd1;
        state_in   = CW'($urandom());
        @(negedge clk);
        if (state_out !== held || !dout_valid || in_ready) stable = 1'b0;
      end
      start = 1'b0;
      check("out_hold_stable", stable, 1);
    end
    check("sb_nonempty", sb_q.size() > 0, 1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check("state_out", state_out, exp);
    $display("[TB] txn a=%0d latency=%0d state_out=%0h", a, cyc - c0, state_out);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    check("idle_after_out", in_ready, 1);
    check("valid_drop", dout_valid, 0);
  endtask

  task automatic check_rounds(input int a_cl, input int rq0);
    check("round_count", rounds_q.size() - rq0, a_cl);
    for (int i = 0; i < a_cl; i++) begin
      if (rq0 + i < rounds_q.size()) begin
        check($sformatf("round%0d", i), rounds_q[rq0 + i], 12 - a_cl + i);
      end
    end
    if (a_cl > 0 && rq0 < rounds_q.size())
      $display("[TB] first round %0d rc=%02h", rounds_q[rq0], rc(rounds_q[rq0]));
  endtask

  initial begin
    int            c0;
    int            en0;
    int            rq0;
    int            g;
    bit            saw_valid;
    logic [CW-1:0] st;

    reset_n    = 1'b0;
    start      = 1'b0;
    num_rounds = 4'd0;
    state_in   = '0;
    dout_ready = 1'b0;
    stub_hang  = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // 1: six rounds
    st = CW'(32'h100);
    sb_q.push_back(st + CW'(6));
    start_perm(4'd6, st, c0, en0, rq0);
    wait_result(6, 37, c0, 0);
    check_rounds(6, rq0);
    check("t1_en_cycles", en_cnt - en0, 6 * STUB_L);

    // 2: zero rounds is a pass-through
    st = CW'(32'hABCD);
    sb_q.push_back(st);
    start_perm(4'd0, st, c0, en0, rq0);
    wait_result(0, 1, c0, 0);
    check("t2_no_core_en", en_cnt - en0, 0);

    // 3: fifteen clamps to twelve
    for (int i = 0; i < CW / 32; i++) st[i*32 +: 32] = $urandom();
    sb_q.push_back(st + CW'(12));
    start_perm(4'd15, st, c0, en0, rq0);
    wait_result(15, 73, c0, 0);
    check_rounds(12, rq0);

    // 4: core never finishes
    stub_hang = 1'b1;
    start_perm(4'd3, CW'(32'h77), c0, en0, rq0);
    g = 0;
    saw_valid = 1'b0;
    while (!error && g < 200) begin
      if (dout_valid) saw_valid = 1'b1;
      @(negedge clk);
      g++;
    end
    check("t4_error", error, 1);
    check("t4_run_cycles", en_cnt - en0, TO);
    check("t4_idle", in_ready, 1);
    check("t4_no_valid", saw_valid, 0);
    stub_hang = 1'b0;
    st = CW'(32'h55);
    sb_q.push_back(st + CW'(1));
    start_perm(4'd1, st, c0, en0, rq0);
    check("t4_error_cleared", error, 0);
    wait_result(1, 7, c0, 0);

    // 5: consumer stalls ten cycles
    st = CW'(32'h1000);
    sb_q.push_back(st + CW'(2));
    start_perm(4'd2, st, c0, en0, rq0);
    wait_result(2, 13, c0, 10);

    // 6: reset during round 3
    st = CW'(32'h2000);
    sb_q.push_back(st + CW'(8));
    start_perm(4'd8, st, c0, en0, rq0);
    g = 0;
    while (!((rounds_q.size() - rq0 >= 2) && core_en) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("t6_in_round3", core_round, 6);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    st = CW'(32'h3000);
    sb_q.push_back(st + CW'(4));
    start_perm(4'd4, st, c0, en0, rq0);
    wait_result(4, 25, c0, 0);
    check_rounds(4, rq0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
